// File: rtl/suart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: byte width, FSM encoding and
// the width helper used for its counters and owner index.
package suart_tx_arbiter_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // $clog2 clamped to at least one bit so degenerate parameters still give legal vectors.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/suart_rr_pick.sv
// Combinational round-robin picker: first asserted request after the pointer,
// wrapping modulo N. Also used by the I2C/SPI bus arbiters.
module suart_rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          any_req
);

    int off;
    int best;

    // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        grant = ptr;
        best  = N;
        off   = 0;
        // off is the rotation distance from ptr+1; the smallest one wins.
        for (int j = 0; j < N; j++) begin
            off = (j + N - 1 - int'(ptr)) % N;
            if (req[j] && (off < best)) begin
                best  = off;
                grant = PW'(j);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/suart_tx_arbiter.sv
// Shares one UART TX byte interface among NUM_REQ requesters; round-robin
// grant held for a whole message, with burst-length and idle-timeout release.
module suart_tx_arbiter
    import suart_tx_arbiter_pkg::*;
#(
    parameter int  NUM_REQ      = 2,
    parameter int  MAX_BURST    = 64,
    parameter int  IDLE_TIMEOUT = 256,
    localparam int OW           = clog2_min1(NUM_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [BYTE_W*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]          req_last_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        tx_valid_o,
    output logic [BYTE_W-1:0]           tx_data_o,
    input  logic                        tx_ready_i,
    output logic [OW-1:0]               owner_o,
    output logic                        busy_o
);

    localparam int BW = clog2_min1(MAX_BURST + 1);
    localparam int IW = clog2_min1(IDLE_TIMEOUT + 1);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [OW-1:0]     owner_next;
    logic [OW-1:0]     pick_grant;
    logic              any_req;
    logic [BW-1:0]     burst_cnt;
    logic [IW-1:0]     idle_cnt;

    logic              owner_valid;
    logic              owner_last;
    logic [BYTE_W-1:0] owner_data;
    logic              can_accept;
    logic              accept;
    logic              transfer;
    logic              rel_last;
    logic              rel_burst;
    logic              rel_idle;

    suart_rr_pick #(
        .N  (NUM_REQ),
        .PW (OW)
    ) u_pick (
        .req     (req_valid_i),
        .ptr     (owner_o),
        .grant   (pick_grant),
        .any_req (any_req)
    );

    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (owner_o == OW'(r)) begin
                owner_valid = req_valid_i[r];
                owner_last  = req_last_i[r];
                owner_data  = req_data_i[BYTE_W*r +: BYTE_W];
            end
        end
    end

    // The output register can take a new byte when empty or emptying this cycle.
    assign can_accept = !tx_valid_o || tx_ready_i;
    assign accept     = (state == ST_LOCK) && owner_valid && can_accept;
    assign transfer   = tx_valid_o && tx_ready_i;

    assign rel_last  = accept && owner_last;
    assign rel_burst = (MAX_BURST != 0) && accept && (burst_cnt == BW'(MAX_BURST - 1));
    assign rel_idle  = (IDLE_TIMEOUT != 0) && (state == ST_LOCK) && !owner_valid
                       && (idle_cnt == IW'(IDLE_TIMEOUT - 1));

    always_comb begin
        req_ready_o = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if ((state == ST_LOCK) && (owner_o == OW'(r))) begin
                req_ready_o[r] = can_accept;
            end
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner_o;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_LOCK;
                    owner_next = pick_grant;
                end
            end
            ST_LOCK: begin
                if (rel_last || rel_burst || rel_idle) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            owner_o <= OW'(NUM_REQ - 1);
        end else begin
            state   <= state_next;
            owner_o <= owner_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
            burst_cnt  <= '0;
            idle_cnt   <= '0;
        end else begin
            if (accept) begin
                tx_valid_o <= 1'b1;
                tx_data_o  <= owner_data;
            end else if (transfer) begin
                tx_valid_o <= 1'b0;
            end

            if (state == ST_IDLE) begin
                burst_cnt <= '0;
                idle_cnt  <= '0;
            end else begin
                if (accept) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
                if (owner_valid) begin
                    idle_cnt <= '0;
                end else if (idle_cnt != '1) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    assign busy_o = (state == ST_LOCK);

endmodule
